br_recovery_ctrl: RTL and testbench

Sequencer for the branch recovery snapshot stack. It allocates branch tags at dispatch and drives the stack's `snapshot_enable`. It collects up to two branch resolutions per cycle from the execute stage and serializes them into the stack's single-op-per-cycle `recovery_request` / `br_correct` interface, oldest mispredict first. It also stalls dispatch while the stack is full or a recovery is in flight.

---
 rtl/br_recovery_ctrl_pkg.sv | 21 ++
 rtl/br_recovery_ctrl_tag_fifo.sv | 60 ++++++
 rtl/br_recovery_ctrl.sv | 158 +++++++++++++++
 tb/tb_br_recovery_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_recovery_ctrl_pkg.sv
// Purpose: shared types for the branch recovery sequencer and its tag FIFO.
// Latency: none (types and constants only).
// Backpressure: none.
`ifndef STACK_NUM
`define STACK_NUM 4
`endif

package br_recovery_ctrl_pkg;

  localparam int STACK_NUM = `STACK_NUM;

  // One-hot branch tag; a higher bit index means an older branch.
  typedef logic [STACK_NUM-1:0] br_tag_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    SETTLE  = 2'd2
  } brc_state_e;

endpackage

// File: rtl/br_recovery_ctrl_tag_fifo.sv
// Purpose: in-order queue of one-hot tags for correctly predicted branches.
// Latency: a write is visible at the head on the next cycle.
// Backpressure: none; the tags are unique, so DEPTH entries can never overflow.
// Ports: two write ports (port 0 is queued ahead of port 1), a head pop, and
//        a purge mask that drops every entry whose tag overlaps it.
module br_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_vld_0,
  input  logic [W-1:0] wr_dat_0,
  input  logic         wr_vld_1,
  input  logic [W-1:0] wr_dat_1,
  input  logic         pop,
  input  logic [W-1:0] purge_mask,
  output logic         head_vld,
  output logic [W-1:0] head_dat
);

  logic [DEPTH-1:0][W-1:0] ent_q, ent_d;
  logic [DEPTH-1:0]        vld_q, vld_d;

  // The next queue image is built by pushing at slot 0, youngest item first.
  // The oldest surviving entry therefore lands in slot 0, and the result is
  // always compacted with no holes left by the pop or the purge.
  always_comb begin
    ent_d = '0;
    vld_d = '0;
    if (wr_vld_1) begin
      ent_d = {ent_d[DEPTH-2:0], wr_dat_1};
      vld_d = {vld_d[DEPTH-2:0], 1'b1};
    end
    if (wr_vld_0) begin
      ent_d = {ent_d[DEPTH-2:0], wr_dat_0};
      vld_d = {vld_d[DEPTH-2:0], 1'b1};
    end
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (vld_q[i] && !(pop && i == 0) && ((ent_q[i] & purge_mask) == '0)) begin
        ent_d = {ent_d[DEPTH-2:0], ent_q[i]};
        vld_d = {vld_d[DEPTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ent_q <= '0;
      vld_q <= '0;
    end else begin
      ent_q <= ent_d;
      vld_q <= vld_d;
    end
  end

  assign head_vld = vld_q[0];
  assign head_dat = ent_q[0];

endmodule

// File: rtl/br_recovery_ctrl.sv
// Purpose: allocates branch tags, and serializes resolutions into snapshot-stack ops, oldest mispredict first.
// Latency: a mispredict gives recovery_request on the next cycle; a correct gives br_correct on the next cycle when idle.
// Backpressure: dispatch_stall holds dispatch while the stack is full, while a recovery is in flight, or while a mispredict is pending.
// Ports: br_dispatch -> snapshot_enable/alloc_tag; res_*_0/1 are the resolutions from execute;
//        recovery_request/br_correct/recovery_mask are the stack ops; squash_mask is the kill broadcast;
//        active_mask mirrors the stack's busy mask.
module br_recovery_ctrl #(
  parameter int STACK_NUM = br_recovery_ctrl_pkg::STACK_NUM
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 br_dispatch,
  input  logic                 res_valid_0,
  input  logic [STACK_NUM-1:0] res_tag_0,
  input  logic                 res_mispredict_0,
  input  logic                 res_valid_1,
  input  logic [STACK_NUM-1:0] res_tag_1,
  input  logic                 res_mispredict_1,
  output logic                 snapshot_enable,
  output logic [STACK_NUM-1:0] alloc_tag,
  output logic                 dispatch_stall,
  output logic                 recovery_request,
  output logic                 br_correct,
  output logic [STACK_NUM-1:0] recovery_mask,
  output logic [STACK_NUM-1:0] squash_mask,
  output logic [STACK_NUM-1:0] active_mask
);

  import br_recovery_ctrl_pkg::*;

  typedef logic [STACK_NUM-1:0] tag_t;

  brc_state_e state_q, state_d;
  tag_t       active_q, active_d;
  tag_t       mis_pend_q, mis_pend_d;
  logic       mis_pend_v_q, mis_pend_v_d;

  tag_t low_oh, alloc_oh, squash_oh, live_mask, cand, head_dat;
  logic full, is_rec, head_vld, acc;
  logic mv0, mv1, cv0, cv1;

  // Allocation: the next tag sits just below the youngest busy tag.
  always_comb begin
    low_oh = '0;
    for (int i = STACK_NUM-1; i >= 0; i--) begin
      if (active_q[i]) begin
        low_oh    = '0;
        low_oh[i] = 1'b1;
      end
    end
    alloc_oh = (active_q == '0) ? {1'b1, {(STACK_NUM-1){1'b0}}} : (low_oh >> 1);
  end

  // Squash covers the mispredicted branch and everything younger.
  always_comb begin
    acc       = 1'b0;
    squash_oh = '0;
    for (int i = STACK_NUM-1; i >= 0; i--) begin
      acc          = acc | mis_pend_q[i];
      squash_oh[i] = acc;
    end
  end

  assign full           = active_q[0];
  assign is_rec         = (state_q == RECOVER);
  assign dispatch_stall = full | (state_q != IDLE) | mis_pend_v_q;
  assign snapshot_enable = br_dispatch & ~dispatch_stall;
  assign alloc_tag      = snapshot_enable ? alloc_oh : '0;

  assign squash_mask = is_rec ? squash_oh : '0;
  // Only tags that are busy and survive this cycle's squash may resolve.
  assign live_mask   = active_q & ~squash_mask;

  assign mv0 = res_valid_0 & res_mispredict_0 & (|(res_tag_0 & live_mask));
  assign mv1 = res_valid_1 & res_mispredict_1 & (|(res_tag_1 & live_mask));

  // Oldest mispredict wins. The pending one competes too, except in RECOVER,
  // where it is being consumed and only strictly older arrivals can replace it.
  always_comb begin
    cand = ((mis_pend_v_q && !is_rec) ? mis_pend_q : '0)
         | (mv0 ? res_tag_0 : '0)
         | (mv1 ? res_tag_1 : '0);
    mis_pend_d = '0;
    for (int i = 0; i < STACK_NUM; i++) begin
      if (cand[i]) begin
        mis_pend_d    = '0;
        mis_pend_d[i] = 1'b1;
      end
    end
    mis_pend_v_d = |cand;
  end

  // One-hot values compare numerically in age order. A correct that is younger
  // than the winning mispredict will be squashed, so it is never queued.
  assign cv0 = res_valid_0 & ~res_mispredict_0 & (|(res_tag_0 & live_mask))
             & ~(mis_pend_v_d & (res_tag_0 < mis_pend_d));
  assign cv1 = res_valid_1 & ~res_mispredict_1 & (|(res_tag_1 & live_mask))
             & ~(mis_pend_v_d & (res_tag_1 < mis_pend_d));

  assign br_correct       = (state_q == IDLE) & ~mis_pend_v_q & head_vld;
  assign recovery_request = is_rec;
  assign recovery_mask    = is_rec ? mis_pend_q : (br_correct ? head_dat : '0);
  assign active_mask      = active_q;

  br_tag_fifo #(
    .DEPTH (STACK_NUM),
    .W     (STACK_NUM)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .wr_vld_0   (cv0),
    .wr_dat_0   (res_tag_0),
    .wr_vld_1   (cv1),
    .wr_dat_1   (res_tag_1),
    .pop        (br_correct),
    .purge_mask (squash_mask),
    .head_vld   (head_vld),
    .head_dat   (head_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mis_pend_v_d) state_d = RECOVER;
      RECOVER: state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    active_d = active_q;
    if (snapshot_enable) active_d = active_d | alloc_oh;
    if (br_correct)      active_d = active_d & ~head_dat;
    if (is_rec)          active_d = active_d & ~squash_oh;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      active_q     <= '0;
      mis_pend_q   <= '0;
      mis_pend_v_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      mis_pend_q   <= mis_pend_d;
      mis_pend_v_q <= mis_pend_v_d;
    end
  end

endmodule

// File: tb/tb_br_recovery_ctrl.sv
module tb_br_recovery_ctrl;
  import br_recovery_ctrl_pkg::*;

  logic    clock = 1'b0;
  logic    reset = 1'b0;
  logic    br_dispatch = 1'b0;
  logic    res_valid_0 = 1'b0, res_valid_1 = 1'b0;
  br_tag_t res_tag_0 = '0, res_tag_1 = '0;
  logic    res_mispredict_0 = 1'b0, res_mispredict_1 = 1'b0;
  logic    snapshot_enable, dispatch_stall, recovery_request, br_correct;
  br_tag_t alloc_tag, recovery_mask, squash_mask, active_mask;

  br_recovery_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .br_dispatch      (br_dispatch),
    .res_valid_0      (res_valid_0),
    .res_tag_0        (res_tag_0),
    .res_mispredict_0 (res_mispredict_0),
    .res_valid_1      (res_valid_1),
    .res_tag_1        (res_tag_1),
    .res_mispredict_1 (res_mispredict_1),
    .snapshot_enable  (snapshot_enable),
    .alloc_tag        (alloc_tag),
    .dispatch_stall   (dispatch_stall),
    .recovery_request (recovery_request),
    .br_correct       (br_correct),
    .recovery_mask    (recovery_mask),
    .squash_mask      (squash_mask),
    .active_mask      (active_mask)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic    is_rec;
    br_tag_t mask;
    br_tag_t squash;
    int      cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every stack op the DUT presents is matched against the queue.
  exp_t e;
  always @(negedge clock) begin
    if (recovery_request === 1'b1 || br_correct === 1'b1) begin
      chk("op_mutex", {31'd0, recovery_request & br_correct}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_op: got rec=%0b cor=%0b mask=%b expected no op (cycle %0d)",
                 recovery_request, br_correct, recovery_mask, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("op_kind", {31'd0, recovery_request}, {31'd0, e.is_rec});
        chk("op_mask", {28'd0, recovery_mask}, {28'd0, e.mask});
        chk("op_squash", {28'd0, squash_mask}, {28'd0, e.squash});
        chk("op_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v0, input br_tag_t t0, input logic m0,
                       input logic v1, input br_tag_t t1, input logic m1);
    res_valid_0 = v0; res_tag_0 = t0; res_mispredict_0 = m0;
    res_valid_1 = v1; res_tag_1 = t1; res_mispredict_1 = m1;
  endtask

  task automatic clr();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic exp_op(input logic is_rec, input br_tag_t mask, input br_tag_t sq, input int dc);
    exp_t x;
    x.is_rec = is_rec; x.mask = mask; x.squash = sq; x.cyc = cyc + dc;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    br_dispatch = 1'b0;
    clr();
    step();
    reset = 1'b1;
  endtask

  task automatic alloc(input int n);
    br_dispatch = 1'b1;
    repeat (n) step();
    br_dispatch = 1'b0;
  endtask

  br_tag_t exp_alloc [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};

  initial begin
    // Reset values
    do_reset();
    chk("rst_active", {28'd0, active_mask}, 32'd0);
    chk("rst_ops", {30'd0, recovery_request, br_correct}, 32'd0);
    chk("rst_masks", {24'd0, recovery_mask, squash_mask}, 32'd0);
    chk("rst_stall_alloc", {27'd0, dispatch_stall, alloc_tag}, 32'd0);

    // Allocation order and stall when full
    br_dispatch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("alloc_tag", {28'd0, alloc_tag}, {28'd0, exp_alloc[i]});
      chk("alloc_snap", {31'd0, snapshot_enable}, {31'd0, (i < 4)});
      chk("alloc_stall", {31'd0, dispatch_stall}, {31'd0, (i == 4)});
      step();
    end
    br_dispatch = 1'b0;
    chk("alloc_active", {28'd0, active_mask}, 32'hF);

    // Single correct
    do_reset();
    alloc(2);
    drive(1'b1, 4'b1000, 1'b0, 1'b0, '0, 1'b0);
    exp_op(1'b0, 4'b1000, 4'b0000, 1);
    step(); clr();
    step();
    chk("correct_active", {28'd0, active_mask}, 32'b0100);

    // Dual mispredict: older (0100) wins
    do_reset();
    alloc(3);
    drive(1'b1, 4'b0010, 1'b1, 1'b1, 4'b0100, 1'b1);
    exp_op(1'b1, 4'b0100, 4'b0111, 1);
    step(); clr();
    chk("rec_stall", {31'd0, dispatch_stall}, 32'd1);
    step();
    chk("settle_stall", {31'd0, dispatch_stall}, 32'd1);
    chk("dual_active", {28'd0, active_mask}, 32'b1000);
    step();
    chk("resume_stall", {31'd0, dispatch_stall}, 32'd0);
    br_dispatch = 1'b1;
    #1;
    chk("resume_alloc", {28'd0, alloc_tag}, 32'b0100);
    br_dispatch = 1'b0;

    // Queued correct purged by a later recovery
    do_reset();
    alloc(3);
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b0010, 1'b0);
    exp_op(1'b0, 4'b1000, 4'b0000, 1);
    step();
    drive(1'b1, 4'b0100, 1'b1, 1'b0, '0, 1'b0);
    exp_op(1'b1, 4'b0100, 4'b0111, 1);
    step(); clr();
    repeat (4) step();
    chk("purge_active", {28'd0, active_mask}, 32'd0);
    chk("purge_stall", {31'd0, dispatch_stall}, 32'd0);

    // Stale resolutions during SETTLE are ignored
    do_reset();
    alloc(3);
    drive(1'b1, 4'b0100, 1'b1, 1'b0, '0, 1'b0);
    exp_op(1'b1, 4'b0100, 4'b0111, 1);
    step(); clr();
    step();
    drive(1'b1, 4'b0010, 1'b0, 1'b1, 4'b0001, 1'b1);
    step(); clr();
    chk("stale_stall", {31'd0, dispatch_stall}, 32'd0);
    chk("stale_active", {28'd0, active_mask}, 32'b1000);
    repeat (3) step();

    // Older mispredict during RECOVER replaces the pending one; younger correct dropped
    do_reset();
    alloc(4);
    drive(1'b1, 4'b0001, 1'b1, 1'b0, '0, 1'b0);
    exp_op(1'b1, 4'b0001, 4'b0001, 1);
    step();
    drive(1'b1, 4'b0100, 1'b1, 1'b1, 4'b0010, 1'b0);
    exp_op(1'b1, 4'b0100, 4'b0111, 3);
    step(); clr();
    step();
    chk("pend_stall", {31'd0, dispatch_stall}, 32'd1);
    repeat (3) step();
    chk("replace_active", {28'd0, active_mask}, 32'b1000);
    chk("replace_stall", {31'd0, dispatch_stall}, 32'd0);

    // Snapshot and correct in the same cycle
    do_reset();
    alloc(2);
    drive(1'b1, 4'b1000, 1'b0, 1'b0, '0, 1'b0);
    exp_op(1'b0, 4'b1000, 4'b0000, 1);
    step(); clr();
    br_dispatch = 1'b1;
    #1;
    chk("snapcor_alloc", {28'd0, alloc_tag}, 32'b0010);
    step();
    br_dispatch = 1'b0;
    chk("snapcor_active", {28'd0, active_mask}, 32'b0110);

    // Dual corrects drain in port order, one per cycle
    do_reset();
    alloc(2);
    drive(1'b1, 4'b0100, 1'b0, 1'b1, 4'b1000, 1'b0);
    exp_op(1'b0, 4'b0100, 4'b0000, 1);
    exp_op(1'b0, 4'b1000, 4'b0000, 2);
    step(); clr();
    repeat (2) step();
    chk("drain_active", {28'd0, active_mask}, 32'd0);

    // Reset asserted during RECOVER
    do_reset();
    alloc(2);
    drive(1'b1, 4'b0100, 1'b1, 1'b0, '0, 1'b0);
    exp_op(1'b1, 4'b0100, 4'b0111, 1);
    step(); clr();
    reset = 1'b0;
    step();
    chk("mrst_ops", {30'd0, recovery_request, br_correct}, 32'd0);
    chk("mrst_masks", {24'd0, recovery_mask, squash_mask}, 32'd0);
    chk("mrst_active", {28'd0, active_mask}, 32'd0);
    chk("mrst_stall", {31'd0, dispatch_stall}, 32'd0);
    reset = 1'b1;
    br_dispatch = 1'b1;
    #1;
    chk("mrst_alloc", {28'd0, alloc_tag}, 32'b1000);
    step();
    br_dispatch = 1'b0;

    repeat (3) step();
    chk("ops_outstanding", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
